// File: rtl/mem_access_defs.sv
// Shared encodings for the data-memory access path: transfer sizes, FSM states
// and the alignment rule used by the MEM-stage access unit and the I/O bridge.
package mem_access_defs;

    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;

    // Size 2'b11 is treated as a word, so anything that is not byte or half needs lsbs of 00.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~lsb[0];
            default:   ok = (lsb == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated store data on the
// way out, lane extraction plus sign/zero extension of load data on the way in.
module byte_lane_align
    import mem_access_defs::*;
(
    input  logic [1:0]            data_size,
    input  logic [1:0]            addr_lsb,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] load_word,
    output logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] store_word,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = load_word[7:0];
        case (addr_lsb)
            2'd0: lane_byte = load_word[7:0];
            2'd1: lane_byte = load_word[15:8];
            2'd2: lane_byte = load_word[23:16];
            2'd3: lane_byte = load_word[31:24];
            default: lane_byte = load_word[7:0];
        endcase
        lane_half = addr_lsb[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        be         = 4'b1111;
        store_word = store_data;
        load_data  = load_word;
        case (data_size)
            SIZE_BYTE: begin
                be         = 4'b0001 << addr_lsb;
                store_word = {4{store_data[7:0]}};
                load_data  = {{24{is_signed & lane_byte[7]}}, lane_byte};
            end
            SIZE_HALF: begin
                be         = addr_lsb[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_data  = {{16{is_signed & lane_half[15]}}, lane_half};
            end
            default: begin
                be         = 4'b1111;
                store_word = store_data;
                load_data  = load_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns load/store requests into byte-enabled
// req/ack bus transactions, stalls the pipeline meanwhile and returns extended load data.
module mem_access_unit
    import mem_access_defs::*;
#(
    parameter int BIT_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0]  req_wdata,
    input  logic                  req_isSigned,
    input  logic [1:0]            req_dataSize,
    output logic                  stall,
    output logic                  rd_valid,
    output logic [BIT_WIDTH-1:0]  rd_data,
    output logic                  addr_err,
    output logic                  timeout_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [BIT_WIDTH-1:0]  bus_wdata,
    input  logic                  bus_ack,
    input  logic [BIT_WIDTH-1:0]  bus_rdata
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] count;
    logic [1:0] lat_size;
    logic [1:0] lat_lsb;
    logic       lat_signed;
    logic       lat_read;

    logic       in_idle;
    logic       req_any;
    logic       aligned;
    logic       accept;
    logic [1:0] sel_size;
    logic [1:0] sel_lsb;
    logic [3:0]           align_be;
    logic [BIT_WIDTH-1:0] align_wdata;
    logic [BIT_WIDTH-1:0] align_load;

    assign in_idle  = (state == IDLE);
    assign req_any  = req_read | req_write;
    assign aligned  = is_aligned(req_dataSize, req_addr[1:0]);
    assign accept   = in_idle & req_any & aligned;
    assign addr_err = in_idle & req_any & ~aligned;
    assign stall    = accept | (state == WAIT_ACK);

    // One aligner serves both directions: the store side is only needed while
    // accepting in IDLE, the load side only while waiting on the latched access.
    assign sel_size = in_idle ? req_dataSize  : lat_size;
    assign sel_lsb  = in_idle ? req_addr[1:0] : lat_lsb;

    byte_lane_align u_align (
        .data_size  (sel_size),
        .addr_lsb   (sel_lsb),
        .is_signed  (lat_signed),
        .store_data (req_wdata),
        .load_word  (bus_rdata),
        .be         (align_be),
        .store_word (align_wdata),
        .load_data  (align_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            lat_size    <= SIZE_BYTE;
            lat_lsb     <= '0;
            lat_signed  <= 1'b0;
            lat_read    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            timeout_err <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
        end else begin
            rd_valid    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= WAIT_ACK;
                        count      <= '0;
                        bus_req    <= 1'b1;
                        bus_we     <= req_write;
                        bus_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_be     <= align_be;
                        bus_wdata  <= align_wdata;
                        lat_size   <= req_dataSize;
                        lat_lsb    <= req_addr[1:0];
                        lat_signed <= req_isSigned;
                        lat_read   <= ~req_write;
                    end
                end
                WAIT_ACK: begin
                    count <= count + 8'd1;
                    if (bus_ack) begin
                        state    <= DONE;
                        bus_req  <= 1'b0;
                        rd_valid <= lat_read;
                        if (lat_read) begin
                            rd_data <= align_load;
                        end
                    end else if (count == TIMEOUT_LAST) begin
                        // Timed-out reads still complete so the pipeline sees a zero result.
                        state       <= DONE;
                        bus_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        rd_valid    <= lat_read;
                        if (lat_read) begin
                            rd_data <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
